// File: rtl/seq_1101_pkg.sv
// Shared definitions for the 1101 frame transmitter and the matching detector.
package seq_1101_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SYNC = 2'b01,
    DATA = 2'b10,
    GAP  = 2'b11
  } state_t;

  localparam logic [3:0] SYNC_PATTERN = 4'b1101;
  localparam int         SYNC_LEN     = 4;

endpackage

// File: rtl/seq_1101_shifter.sv
// Payload register for seq_1101_tx: parallel load, shift left with zero fill,
// MSB tap and even parity of the word captured at load time.
module seq_1101_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  output logic              msb,
  output logic              parity
);

  logic [DATA_W-1:0] data;
  logic              par;

  // Parity is latched with the word so later shifts cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      par  <= 1'b0;
    end else if (load) begin
      data <= load_data;
      par  <= ^load_data;
    end else if (shift) begin
      data <= data << 1;
    end
  end

  assign msb    = data[DATA_W-1];
  assign parity = par;

endmodule

// File: rtl/seq_1101_tx.sv
// Serial frame transmitter: 1101 sync header, MSB-first payload, idle gap.
// Define SEQ_1101_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_1101_tx
  import seq_1101_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              busy,
  output logic [1:0]        state_out
);

  localparam int BIT_CNT_W = $clog2(DATA_W + 1);
  localparam int GAP_CNT_W = $clog2(GAP_CYCLES + 1);

  localparam logic [BIT_CNT_W-1:0] BIT_LOAD  = BIT_CNT_W'(DATA_W);
  localparam logic [BIT_CNT_W-1:0] BIT_ONE   = BIT_CNT_W'(1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD  = GAP_CNT_W'(GAP_CYCLES);
  localparam logic [GAP_CNT_W-1:0] GAP_ONE   = GAP_CNT_W'(1);
  localparam logic [1:0]           SYNC_LAST = 2'(SYNC_LEN - 1);
  localparam logic [1:0]           SYNC_TOP  = 2'(SYNC_LEN - 2);

`ifdef SEQ_1101_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_t               state, state_n;
  logic [1:0]           sync_cnt, sync_cnt_n;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [GAP_CNT_W-1:0] gap_cnt, gap_cnt_n;
  logic                 par_pending, par_pending_n;
  logic                 ser_out_n, ser_valid_n, frame_start_n, busy_n;
  logic                 take, start, load, shift;
  logic                 sh_msb, sh_parity;
  logic [1:0]           sync_idx;

  seq_1101_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .load_data (in_data),
    .msb       (sh_msb),
    .parity    (sh_parity)
  );

  assign in_ready  = (state == IDLE) || ((state == GAP) && (gap_cnt == GAP_ONE));
  assign take      = in_valid && in_ready;
  assign sync_idx  = SYNC_TOP - sync_cnt;
  assign state_out = state;

  // State and counters describe the bit currently on ser_out, so the output
  // registers are loaded from the next-cycle decode below.
  always_comb begin
    state_n       = state;
    sync_cnt_n    = sync_cnt;
    bit_cnt_n     = bit_cnt;
    gap_cnt_n     = gap_cnt;
    par_pending_n = par_pending;
    ser_out_n     = 1'b0;
    ser_valid_n   = 1'b0;
    frame_start_n = 1'b0;
    start         = 1'b0;
    load          = 1'b0;
    shift         = 1'b0;

    case (state)
      IDLE: begin
        if (take) start = 1'b1;
      end
      SYNC: begin
        ser_valid_n = 1'b1;
        if (sync_cnt == SYNC_LAST) begin
          state_n   = DATA;
          ser_out_n = sh_msb;
          shift     = 1'b1;
          bit_cnt_n = bit_cnt - BIT_ONE;
        end else begin
          sync_cnt_n = sync_cnt + 2'd1;
          ser_out_n  = SYNC_PATTERN[sync_idx];
        end
      end
      DATA: begin
        if (bit_cnt != '0) begin
          ser_out_n   = sh_msb;
          ser_valid_n = 1'b1;
          shift       = 1'b1;
          bit_cnt_n   = bit_cnt - BIT_ONE;
        end else if (par_pending) begin
          ser_out_n     = sh_parity;
          ser_valid_n   = 1'b1;
          par_pending_n = 1'b0;
        end else begin
          state_n   = GAP;
          gap_cnt_n = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_ONE) begin
          if (take) start = 1'b1;
          else      state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt - GAP_ONE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (start) begin
      state_n       = SYNC;
      sync_cnt_n    = '0;
      bit_cnt_n     = BIT_LOAD;
      par_pending_n = PAR_EN;
      ser_out_n     = SYNC_PATTERN[3];
      ser_valid_n   = 1'b1;
      frame_start_n = 1'b1;
      load          = 1'b1;
    end

    busy_n = (state_n == SYNC) || (state_n == DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sync_cnt    <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      par_pending <= 1'b0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      sync_cnt    <= sync_cnt_n;
      bit_cnt     <= bit_cnt_n;
      gap_cnt     <= gap_cnt_n;
      par_pending <= par_pending_n;
      ser_out     <= ser_out_n;
      ser_valid   <= ser_valid_n;
      frame_start <= frame_start_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_seq_1101_tx.sv
// Directed bench for seq_1101_tx (DATA_W=8, GAP_CYCLES=2); follows
// SEQ_1101_TX_PARITY_EN when the design is built with it.
module tb_seq_1101_tx;

`ifdef SEQ_1101_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = 12 + PAR;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, ser_out, ser_valid, frame_start, busy;
  logic [1:0] state_out;

  int n_cmp = 0;
  int n_err = 0;

  seq_1101_tx #(.DATA_W(8), .GAP_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one word from IDLE and checks every frame bit, the gap and a
  // reference overlapping-1101 detector fed from ser_out.
  task automatic run_frame(input logic [7:0] d, input int exp_det);
    logic [11:0] exp_bits;
    logic [3:0]  hist;
    int          det;
    exp_bits = {4'b1101, d};
    hist     = 4'b0000;
    det      = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("bit%0d_%0h", i, d), {31'b0, ser_out}, {31'b0, exp_bits[11-i]});
      check($sformatf("valid%0d_%0h", i, d), {31'b0, ser_valid}, 32'd1);
      check($sformatf("fstart%0d_%0h", i, d), {31'b0, frame_start}, {31'b0, (i == 0)});
      check($sformatf("busy%0d_%0h", i, d), {31'b0, busy}, 32'd1);
      hist = {hist[2:0], ser_out};
      if (hist == 4'b1101) det++;
      @(negedge clk);
    end
`ifdef SEQ_1101_TX_PARITY_EN
    check($sformatf("parity_%0h", d), {31'b0, ser_out}, {31'b0, ^d});
    check($sformatf("parity_valid_%0h", d), {31'b0, ser_valid}, 32'd1);
    hist = {hist[2:0], ser_out};
    if (hist == 4'b1101) det++;
    @(negedge clk);
`endif
    check($sformatf("gap1_valid_%0h", d), {31'b0, ser_valid}, 32'd0);
    check($sformatf("gap1_out_%0h", d), {31'b0, ser_out}, 32'd0);
    check($sformatf("gap1_busy_%0h", d), {31'b0, busy}, 32'd0);
    check($sformatf("gap1_state_%0h", d), {30'b0, state_out}, 32'd3);
    check($sformatf("gap1_ready_%0h", d), {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check($sformatf("gap2_ready_%0h", d), {31'b0, in_ready}, 32'd1);
    check($sformatf("gap2_state_%0h", d), {30'b0, state_out}, 32'd3);
    @(negedge clk);
    check($sformatf("idle_state_%0h", d), {30'b0, state_out}, 32'd0);
    check($sformatf("idle_ready_%0h", d), {31'b0, in_ready}, 32'd1);
    check($sformatf("detect_%0h", d), det, exp_det);
  endtask

  initial begin
    logic [63:0] stream;
    logic [11:0] got1, got2;
    int          fs1, fs2, rdy_cnt, rdy_at;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ser_out", {31'b0, ser_out}, 32'd0);
    check("rst_ser_valid", {31'b0, ser_valid}, 32'd0);
    check("rst_frame_start", {31'b0, frame_start}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_state", {30'b0, state_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'b0, in_ready}, 32'd1);

    run_frame(8'hA5, 2);
    run_frame(8'h07, 1);

    // Back-to-back with in_valid held high; in_data changes mid-frame.
    stream  = '0;
    fs1     = -1;
    fs2     = -1;
    rdy_cnt = 0;
    rdy_at  = -1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk);
    for (int c = 1; c <= 2 * FL + 4; c++) begin
      @(negedge clk);
      stream[c] = ser_out;
      if (frame_start) begin
        if (fs1 < 0) fs1 = c;
        else if (fs2 < 0) begin
          fs2 = c;
          in_valid = 1'b0;
        end
      end
      if (in_ready && c <= FL + 2) begin
        rdy_cnt++;
        rdy_at = c;
      end
      if (c == 1) in_data = 8'h00;
    end
    for (int i = 0; i < 12; i++) begin
      got1[11-i] = stream[1 + i];
      got2[11-i] = stream[FL + 3 + i];
    end
    check("b2b_first_start", fs1, 1);
    check("b2b_start_spacing", fs2 - fs1, FL + 2);
    check("b2b_ready_pulses", rdy_cnt, 1);
    check("b2b_ready_cycle", rdy_at, FL + 2);
    check("b2b_frame1", {20'b0, got1}, 32'hDFF);
    check("b2b_frame2", {20'b0, got2}, 32'hD00);
    check("b2b_gap_bits", {30'b0, stream[FL+2], stream[FL+1]}, 32'd0);
    @(negedge clk);
    check("b2b_idle", {30'b0, state_out}, 32'd0);

    // Reset in the middle of the payload.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_state_data", {30'b0, state_out}, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_ser_out", {31'b0, ser_out}, 32'd0);
    check("mid_rst_ser_valid", {31'b0, ser_valid}, 32'd0);
    check("mid_rst_state", {30'b0, state_out}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_idle_out", {31'b0, ser_out}, 32'd0);

    run_frame(8'h0D, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_1101_tx.md
# seq_1101_tx

Serial frame transmitter that drives the 1101 sequence detector's input. Each accepted payload word goes out one bit per clock as a frame: the fixed 4-bit sync header 1101, then the payload MSB-first, then an idle gap. The block provides stimulus for the detector in loopback benches and on-chip self-test. It also serves as the transmit end of the single-wire serial link whose receive end keys on the 1101 header.

## Interface
- DATA_W, default 8: payload width in bits. Legal range 1 to 32.
- GAP_CYCLES, default 2: idle cycles after each frame. Minimum 1.
- clk, input, 1: the single clock. All logic is rising-edge.
- rst, input, 1: reset. Synchronous and active-high.
- in_valid, input, 1: payload word offered.
- in_data, input, DATA_W: payload word.
- in_ready, output, 1: the block can accept a word this cycle.
- ser_out, output, 1: serial bit. Idle level is 0.
- ser_valid, output, 1: ser_out carries a frame bit (sync, payload, or parity).
- frame_start, output, 1: one-cycle pulse coincident with the first sync bit.
- busy, output, 1: a frame is in progress; covers SYNC and DATA, excludes GAP.
- state_out, output, 2: current FSM state, for debug.

## Operation
- FSM states: IDLE=00, SYNC=01, DATA=10, GAP=11.
- A transfer occurs on an edge where in_valid and in_ready are both high. The block captures in_data into the shift register and loads the bit counter.
- IDLE: in_ready=1. A transfer moves the FSM to SYNC; otherwise it stays in IDLE.
- SYNC: emits 1,1,0,1 over four cycles, indexed by a 2-bit counter, then moves to DATA.
- DATA: emits shift-register bits MSB-first over DATA_W cycles, shifting left with 0 fill. With parity enabled, one extra parity bit follows. Then moves to GAP.
- GAP: ser_out=0 and ser_valid=0 for GAP_CYCLES cycles.
  - in_ready=1 only in the final GAP cycle.
  - A transfer in that cycle goes straight to SYNC, giving back-to-back frames with exactly GAP_CYCLES idle bits between them.
  - With no transfer, the FSM goes to IDLE.
- in_ready=0 in SYNC, DATA, and all but the final GAP cycle. in_data is ignored whenever in_ready is 0.
- Payloads containing 1101 are sent unmodified; there is no bit stuffing.
- Reset, including mid-frame: on the next edge the FSM is IDLE, counters are 0, and the shift register is 0. The partial frame is abandoned and not resumed.
- Reset values:
  - ser_out=0, ser_valid=0, frame_start=0, busy=0, state_out=00.
  - in_ready=1 from the first cycle after rst deasserts.

## Timing
- All outputs except in_ready are registered. in_ready decodes combinationally from state and the gap counter, with no input-to-output path.
- For a transfer at edge k:
  - Sync bits are on ser_out during cycles k+1 to k+4.
  - Payload bits are on ser_out during cycles k+5 to k+4+DATA_W.
  - Parity, when enabled, is on ser_out at cycle k+5+DATA_W.
- frame_start=1 only in cycle k+1.
- Frame length: 4+DATA_W bits, plus 1 with parity. Frame period: frame length plus GAP_CYCLES.
- Counter widths:
  - Bit counter: clog2(DATA_W+1) bits.
  - Gap counter: clog2(GAP_CYCLES+1) bits.
  - Neither counter wraps mid-phase; each reloads on phase entry.

## Configuration
- SEQ_1101_TX_PARITY_EN defined:
  - One even-parity bit (XOR of all payload bits) is appended after the payload, with ser_valid=1.
  - Parity is computed at capture, not on the fly.
- SEQ_1101_TX_PARITY_EN undefined: no parity bit is sent, and DATA moves to GAP directly after bit 0.

## Structure
- A shared package seq_1101_pkg holds:
  - State encoding constants IDLE, SYNC, DATA, GAP (2-bit).
  - SYNC_PATTERN = 4'b1101 and SYNC_LEN = 4.
  - The detector uses the same package.
- One sub-module, seq_1101_shifter: a DATA_W-bit load/shift-left register with an MSB output and a parity output.
- The FSM, counters, and handshake live in the top module.

## Test plan
Unless noted, DATA_W=8 and GAP_CYCLES=2.

- Single frame: transfer 0xA5 at edge k -> ser_out reads 1,1,0,1,1,0,1,0,0,1,0,1 over k+1 to k+12. frame_start is high at k+1, ser_valid is high for 12 cycles, and busy drops at k+13.
- Parity build: 0xA5 -> a 13th bit of 0. 0x07 -> a 13th bit of 1.
- Back-to-back: in_valid held high with 0xFF then 0x00 -> the second frame_start lands exactly 14 cycles after the first (12+2), and in_ready pulses only in the final GAP cycle.
- Stall: in_valid asserted while state=DATA -> no capture. in_data changes mid-frame do not alter ser_out.
- Reset mid-frame: rst=1 during payload bit 3 -> next cycle ser_out=0, ser_valid=0, state_out=00, in_ready=1. A new transfer then starts a clean frame.
- Loopback: ser_out drives the 1101 detector -> the detector flags the sync header once per frame. With payload 0x0D, the header and payload overlap sequences are checked against the detector's reference model.
